ila_capture_ctrl: RTL and testbench
===================================

# ila_capture_ctrl

Capture sequencer for the ILA sample buffer, the 2-port 512x20 RAM macro. It writes qualified samples circularly through RAM port A with a programmable pre-trigger depth, then freezes the window after the trigger. It then streams the full window out through RAM port B over a valid/ready interface to the readout/JTAG side. Both RAM ports are clocked from CLK_I.

## Interface
- P_DATA_WIDTH, 20, sample/RAM word width
- P_ADDR_WIDTH, 9, RAM address width
- P_COUNT, 512, buffer depth (2^P_ADDR_WIDTH)

- CLK_I  in  1  clock; also drives RAM A_CLK_I and B_CLK_I
- RSTN_I  in  1  reset; one clock, synchronous, active-low
- ARM_I  in  1  start capture; accepted only in IDLE or DONE
- PRE_I  in  P_ADDR_WIDTH  pre-trigger sample count, 0..P_COUNT-1; latched on accepted ARM_I
- SAMPLE_I  in  P_DATA_WIDTH  probe sample
- SAMPLE_VLD_I  in  1  sample qualifier; only qualified cycles are stored or counted
- TRIG_I  in  1  trigger; honoured only in ARMED with SAMPLE_VLD_I=1
- RD_REQ_I  in  1  start readout; honoured only in DONE
- RD_RDY_I  in  1  readout sink ready
- RD_DATA_O  out  P_DATA_WIDTH  readout word
- RD_VLD_O  out  1  RD_DATA_O valid
- RD_LAST_O  out  1  marks word P_COUNT-1 of the window
- DONE_O  out  1  window frozen; high in DONE only
- STATE_O  out  3  state encoding, for status register
- TRIG_ADDR_O  out  P_ADDR_WIDTH  RAM address of trigger sample
- RAM_A_CS_O, RAM_A_WE_O  out  1  port A write strobes
- RAM_A_ADDR_O  out  P_ADDR_WIDTH  port A address
- RAM_A_DW_O  out  P_DATA_WIDTH  port A write data
- RAM_B_CS_O, RAM_B_RE_O  out  1  port B read strobes
- RAM_B_ADDR_O  out  P_ADDR_WIDTH  port B address
- RAM_B_DR_I  in  P_DATA_WIDTH  port B read data
- Integration tie-offs: A_BM_I all ones, A_RE_I 0, B_WE_I 0, B_DW_I 0, B_BM_I 0, DLY inputs 0

## Operation
- States (STATE_O): IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4, RD_ISSUE=5, RD_WAIT=6, RD_HOLD=7.
- IDLE/DONE + ARM_I: clear wr_ptr and fill_cnt, latch pre=PRE_I, clear DONE_O.
  - pre=0: go to ARMED.
  - otherwise: go to PRE.
- PRE: each qualified sample is written at wr_ptr; wr_ptr++ mod P_COUNT; fill_cnt++. After the pre-th write, go to ARMED. TRIG_I is ignored.
- ARMED: qualified samples are written circularly. A qualified sample with TRIG_I=1 is written, TRIG_ADDR_O←wr_ptr, post_cnt←P_COUNT-1-pre.
  - post_cnt=0 (pre=P_COUNT-1): go to DONE.
  - otherwise: go to POST.
- POST: each qualified sample is written and post_cnt decrements. The write that takes post_cnt to 0 goes to DONE. TRIG_I is ignored.
- DONE: hold DONE_O=1. ARM_I takes priority over RD_REQ_I when both are high.
  - RD_REQ_I: rd_ptr←TRIG_ADDR_O-pre mod P_COUNT, rd_cnt←0, go to RD_ISSUE.
- RD_ISSUE: assert RAM_B_CS_O=RAM_B_RE_O=1 at rd_ptr for one cycle, then go to RD_WAIT.
- RD_WAIT: register RAM_B_DR_I into RD_DATA_O, go to RD_HOLD.
- RD_HOLD: RD_VLD_O=1; RD_LAST_O=1 when rd_cnt=P_COUNT-1. On RD_VLD_O&RD_RDY_I:
  - last word: go to IDLE.
  - otherwise: rd_ptr++ mod P_COUNT, rd_cnt++, go to RD_ISSUE.
- ARM_I is ignored in PRE, ARMED, POST and the RD_* states. RD_REQ_I is ignored outside DONE.
- Counter widths:
  - wr_ptr and rd_ptr: P_ADDR_WIDTH, natural wrap.
  - fill_cnt and post_cnt: P_ADDR_WIDTH.
  - rd_cnt: P_ADDR_WIDTH; the compare with P_COUNT-1 cannot overflow.
- Window: exactly P_COUNT words, oldest first. The trigger sample is word index pre.

## Timing
- Reset: all outputs 0 (STATE_O=IDLE, TRIG_ADDR_O=0), all counters 0. RAM contents untouched.
- Reset asserted mid-capture or mid-readout aborts the operation. Next cycle is IDLE, with no RAM strobe active.
- Write path is registered:
  - sample accepted at edge N → RAM_A_CS_O/WE_O/ADDR_O/DW_O driven during cycle N+1;
  - RAM writes at edge N+1;
  - strobes low when no sample is accepted.
- DONE_O rises at the edge that accepts the final sample. The final write strobe is still active in the first DONE cycle.
- The earliest port B read is 2 cycles after DONE entry, so reads never collide with capture writes.
- Readout: RD_VLD_O rises 2 cycles after RD_ISSUE entry. RD_DATA_O and RD_LAST_O are held stable while RD_RDY_I=0. Steady throughput is 1 word per 3 cycles.
- RAM_B_CS_O is low except in RD_ISSUE. RAM_A_CS_O is never high in RD_* states.

## Test plan
- PRE_I=100, SAMPLE_I=running index, always valid, TRIG_I at index 300 → TRIG_ADDR_O=300, DONE after index 711; readout 512 words 200..711, RD_LAST_O on 711.
- PRE_I=0, TRIG_I with first valid sample → STATE_O 0→2→3→4, TRIG_ADDR_O=0; readout 0..511.
- PRE_I=511, TRIG_I pulsed during PRE (ignored), then at index 600 → direct ARMED→DONE, TRIG_ADDR_O=88; readout 89..600.
- SAMPLE_VLD_I toggling 1/0 in PRE/POST, TRIG_I high on an invalid cycle → no counter advance, no A strobe, trigger ignored; window identical to the gap-free case.
- RD_RDY_I held low 5 cycles in RD_HOLD → RD_VLD_O, RD_DATA_O and RD_LAST_O stable, RAM_B_CS_O=0 throughout.
- RSTN_I low in POST and again mid-readout → next cycle all outputs 0, STATE_O=0. A subsequent ARM_I/capture completes correctly.

Source files
------------

// File: rtl/ila_capture_ctrl.sv
// Capture sequencer for the ILA sample buffer: circular pre/post-trigger capture through
// RAM port A, then a paced valid/ready readout of the frozen window through RAM port B.
module ila_capture_ctrl #(
    parameter int P_DATA_WIDTH = 20,
    parameter int P_ADDR_WIDTH = 9,
    parameter int P_COUNT      = 512
) (
    input  logic                    CLK_I,
    input  logic                    RSTN_I,
    input  logic                    ARM_I,
    input  logic [P_ADDR_WIDTH-1:0] PRE_I,
    input  logic [P_DATA_WIDTH-1:0] SAMPLE_I,
    input  logic                    SAMPLE_VLD_I,
    input  logic                    TRIG_I,
    input  logic                    RD_REQ_I,
    input  logic                    RD_RDY_I,
    output logic [P_DATA_WIDTH-1:0] RD_DATA_O,
    output logic                    RD_VLD_O,
    output logic                    RD_LAST_O,
    output logic                    DONE_O,
    output logic [2:0]              STATE_O,
    output logic [P_ADDR_WIDTH-1:0] TRIG_ADDR_O,
    output logic                    RAM_A_CS_O,
    output logic                    RAM_A_WE_O,
    output logic [P_ADDR_WIDTH-1:0] RAM_A_ADDR_O,
    output logic [P_DATA_WIDTH-1:0] RAM_A_DW_O,
    output logic                    RAM_B_CS_O,
    output logic                    RAM_B_RE_O,
    output logic [P_ADDR_WIDTH-1:0] RAM_B_ADDR_O,
    input  logic [P_DATA_WIDTH-1:0] RAM_B_DR_I
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POST     = 3'd3,
        ST_DONE     = 3'd4,
        ST_RD_ISSUE = 3'd5,
        ST_RD_WAIT  = 3'd6,
        ST_RD_HOLD  = 3'd7
    } state_t;

    localparam logic [P_ADDR_WIDTH-1:0] LAST_IDX = P_ADDR_WIDTH'(P_COUNT - 1);
    localparam logic [P_ADDR_WIDTH-1:0] ONE      = P_ADDR_WIDTH'(1);
    localparam logic [P_ADDR_WIDTH-1:0] ZERO     = P_ADDR_WIDTH'(0);

    state_t                  state_r;
    logic [P_ADDR_WIDTH-1:0] wr_ptr_r;
    logic [P_ADDR_WIDTH-1:0] fill_cnt_r;
    logic [P_ADDR_WIDTH-1:0] pre_r;
    logic [P_ADDR_WIDTH-1:0] post_cnt_r;
    logic [P_ADDR_WIDTH-1:0] rd_ptr_r;
    logic [P_ADDR_WIDTH-1:0] rd_cnt_r;
    logic [P_ADDR_WIDTH-1:0] trig_addr_r;
    logic [P_DATA_WIDTH-1:0] rd_data_r;
    logic                    rd_vld_r;
    logic                    rd_last_r;
    logic                    done_r;
    logic                    a_cs_r;
    logic [P_ADDR_WIDTH-1:0] a_addr_r;
    logic [P_DATA_WIDTH-1:0] a_dw_r;
    logic                    b_cs_r;

    // Sequencer: state, counters and all registered outputs.
    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= ZERO;
            fill_cnt_r  <= ZERO;
            pre_r       <= ZERO;
            post_cnt_r  <= ZERO;
            rd_ptr_r    <= ZERO;
            rd_cnt_r    <= ZERO;
            trig_addr_r <= ZERO;
            rd_data_r   <= {P_DATA_WIDTH{1'b0}};
            rd_vld_r    <= 1'b0;
            rd_last_r   <= 1'b0;
            done_r      <= 1'b0;
            a_cs_r      <= 1'b0;
            a_addr_r    <= ZERO;
            a_dw_r      <= {P_DATA_WIDTH{1'b0}};
            b_cs_r      <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            a_cs_r <= 1'b0;
            b_cs_r <= 1'b0;
            if ((state_r == ST_PRE || state_r == ST_ARMED || state_r == ST_POST) && SAMPLE_VLD_I) begin
                a_cs_r   <= 1'b1;
                a_addr_r <= wr_ptr_r;
                a_dw_r   <= SAMPLE_I;
                wr_ptr_r <= wr_ptr_r + ONE;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (ARM_I) begin
                        wr_ptr_r   <= ZERO;
                        fill_cnt_r <= ZERO;
                        pre_r      <= PRE_I;
                        done_r     <= 1'b0;
                        state_r    <= (PRE_I == ZERO) ? ST_ARMED : ST_PRE;
                    end else if (state_r == ST_DONE && RD_REQ_I) begin
                        rd_ptr_r <= trig_addr_r - pre_r;
                        rd_cnt_r <= ZERO;
                        b_cs_r   <= 1'b1;
                        done_r   <= 1'b0;
                        state_r  <= ST_RD_ISSUE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_PRE: begin
                    if (SAMPLE_VLD_I) begin
                        fill_cnt_r <= fill_cnt_r + ONE;
                        if (fill_cnt_r + ONE == pre_r) begin
                            state_r <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (SAMPLE_VLD_I && TRIG_I) begin
                        trig_addr_r <= wr_ptr_r;
                        post_cnt_r  <= LAST_IDX - pre_r;
                        if (pre_r == LAST_IDX) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (SAMPLE_VLD_I) begin
                        post_cnt_r <= post_cnt_r - ONE;
                        if (post_cnt_r == ONE) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    state_r <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rd_data_r <= RAM_B_DR_I;
                    rd_vld_r  <= 1'b1;
                    rd_last_r <= (rd_cnt_r == LAST_IDX);
                    state_r   <= ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (RD_RDY_I) begin
                        rd_vld_r  <= 1'b0;
                        rd_last_r <= 1'b0;
                        if (rd_cnt_r == LAST_IDX) begin
                            state_r <= ST_IDLE;
                        end else begin
                            rd_ptr_r <= rd_ptr_r + ONE;
                            rd_cnt_r <= rd_cnt_r + ONE;
                            b_cs_r   <= 1'b1;
                            state_r  <= ST_RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign STATE_O      = state_r;
    assign DONE_O       = done_r;
    assign TRIG_ADDR_O  = trig_addr_r;
    assign RD_DATA_O    = rd_data_r;
    assign RD_VLD_O     = rd_vld_r;
    assign RD_LAST_O    = rd_last_r;
    assign RAM_A_CS_O   = a_cs_r;
    assign RAM_A_WE_O   = a_cs_r;
    assign RAM_A_ADDR_O = a_addr_r;
    assign RAM_A_DW_O   = a_dw_r;
    assign RAM_B_CS_O   = b_cs_r;
    assign RAM_B_RE_O   = b_cs_r;
    assign RAM_B_ADDR_O = rd_ptr_r;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Randomized bench for ila_capture_ctrl: a RAM model plus a sample-history reference model
// that derives window contents, trigger address and state sequence from sample counts.
module tb_ila_capture_ctrl;
    localparam int DW = 20;
    localparam int AW = 9;
    localparam int N  = 512;

    logic          CLK_I = 1'b0;
    logic          RSTN_I, ARM_I, SAMPLE_VLD_I, TRIG_I, RD_REQ_I, RD_RDY_I;
    logic [AW-1:0] PRE_I;
    logic [DW-1:0] SAMPLE_I;
    logic [DW-1:0] RD_DATA_O, RAM_A_DW_O, RAM_B_DR_I;
    logic          RD_VLD_O, RD_LAST_O, DONE_O;
    logic [2:0]    STATE_O;
    logic [AW-1:0] TRIG_ADDR_O, RAM_A_ADDR_O, RAM_B_ADDR_O;
    logic          RAM_A_CS_O, RAM_A_WE_O, RAM_B_CS_O, RAM_B_RE_O;

    logic [DW-1:0] ram_mem [N];
    logic [DW-1:0] ram_dr;
    logic [DW-1:0] samp_q [$];
    int            n_checks = 0;
    int            n_errors = 0;

    ila_capture_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_COUNT(N)) dut (
        .CLK_I(CLK_I), .RSTN_I(RSTN_I), .ARM_I(ARM_I), .PRE_I(PRE_I),
        .SAMPLE_I(SAMPLE_I), .SAMPLE_VLD_I(SAMPLE_VLD_I), .TRIG_I(TRIG_I),
        .RD_REQ_I(RD_REQ_I), .RD_RDY_I(RD_RDY_I), .RD_DATA_O(RD_DATA_O),
        .RD_VLD_O(RD_VLD_O), .RD_LAST_O(RD_LAST_O), .DONE_O(DONE_O),
        .STATE_O(STATE_O), .TRIG_ADDR_O(TRIG_ADDR_O),
        .RAM_A_CS_O(RAM_A_CS_O), .RAM_A_WE_O(RAM_A_WE_O),
        .RAM_A_ADDR_O(RAM_A_ADDR_O), .RAM_A_DW_O(RAM_A_DW_O),
        .RAM_B_CS_O(RAM_B_CS_O), .RAM_B_RE_O(RAM_B_RE_O),
        .RAM_B_ADDR_O(RAM_B_ADDR_O), .RAM_B_DR_I(RAM_B_DR_I)
    );

    always #5 CLK_I = ~CLK_I;

    // Synchronous 2-port RAM macro model.
    always @(posedge CLK_I) begin
        if (RAM_A_CS_O && RAM_A_WE_O) ram_mem[RAM_A_ADDR_O] <= RAM_A_DW_O;
        if (RAM_B_CS_O && RAM_B_RE_O) ram_dr <= ram_mem[RAM_B_ADDR_O];
    end
    assign RAM_B_DR_I = ram_dr;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Expected state after k qualified samples of a capture.
    function automatic int exp_state(input int k, input int pre, input int trig_idx);
        int total = trig_idx + N - pre;
        if (k < pre) return 1;
        if (k <= trig_idx) return 2;
        if (k < total) return 3;
        return 4;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_state"}, 32'(STATE_O), 32'd0);
        check_eq({tag, "_done"}, 32'(DONE_O), 32'd0);
        check_eq({tag, "_trig_addr"}, 32'(TRIG_ADDR_O), 32'd0);
        check_eq({tag, "_a_strobes"}, 32'({RAM_A_CS_O, RAM_A_WE_O}), 32'd0);
        check_eq({tag, "_a_addr_dw"}, 32'(RAM_A_ADDR_O) | 32'(RAM_A_DW_O), 32'd0);
        check_eq({tag, "_b_strobes"}, 32'({RAM_B_CS_O, RAM_B_RE_O}), 32'd0);
        check_eq({tag, "_b_addr"}, 32'(RAM_B_ADDR_O), 32'd0);
        check_eq({tag, "_rd_out"}, 32'({RD_VLD_O, RD_LAST_O}) | 32'(RD_DATA_O), 32'd0);
    endtask

    // Called at a falling edge; pulses reset for one clock and checks the result.
    task automatic do_reset(input string tag);
        RSTN_I = 1'b0; ARM_I = 1'b0; SAMPLE_VLD_I = 1'b0; TRIG_I = 1'b0;
        RD_REQ_I = 1'b0; RD_RDY_I = 1'b0;
        @(negedge CLK_I);
        check_reset(tag);
        RSTN_I = 1'b1;
    endtask

    task automatic run_capture(input int pre, input int trig_idx, input bit gaps,
                               input bit idx_data, input bit with_rdreq, input int abort_k);
        int k = 0;
        int cyc = 0;
        int total = trig_idx + N - pre;
        bit vld, trg;
        logic [DW-1:0] d;
        samp_q.delete();
        PRE_I = AW'(pre); ARM_I = 1'b1; RD_REQ_I = with_rdreq;
        SAMPLE_VLD_I = 1'b0; TRIG_I = 1'b0;
        @(negedge CLK_I);
        ARM_I = 1'b0; RD_REQ_I = 1'b0;
        check_eq("arm_state", 32'(STATE_O), 32'(exp_state(0, pre, trig_idx)));
        check_eq("arm_done", 32'(DONE_O), 32'd0);
        while (k < total && cyc < 20000 && !(abort_k >= 0 && k == abort_k)) begin
            vld = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            d = idx_data ? DW'(k) : DW'($urandom);
            if (vld) trg = (k == trig_idx) || ((k < pre || k > trig_idx) && $urandom_range(0, 5) == 0);
            else     trg = ($urandom_range(0, 2) == 0);
            SAMPLE_VLD_I = vld; TRIG_I = trg; SAMPLE_I = d;
            @(negedge CLK_I);
            cyc++;
            if (vld) begin
                check_eq("a_strobe", 32'({RAM_A_CS_O, RAM_A_WE_O}), 32'd3);
                check_eq("a_addr", 32'(RAM_A_ADDR_O), 32'(k % N));
                check_eq("a_data", 32'(RAM_A_DW_O), 32'(d));
                samp_q.push_back(d);
                k++;
                if (k == trig_idx + 1) check_eq("trig_addr", 32'(TRIG_ADDR_O), 32'(trig_idx % N));
                check_eq("cap_done", 32'(DONE_O), 32'(k == total));
            end else begin
                check_eq("a_idle", 32'({RAM_A_CS_O, RAM_A_WE_O}), 32'd0);
            end
            check_eq("cap_state", 32'(STATE_O), 32'(exp_state(k, pre, trig_idx)));
        end
        SAMPLE_VLD_I = 1'b0; TRIG_I = 1'b0;
        if (abort_k < 0) check_eq("cap_complete", 32'(k), 32'(total));
    endtask

    task automatic run_readout(input int pre, input int trig_idx, input bit stall, input int abort_i);
        int base = trig_idx - pre;
        int n;
        RD_REQ_I = 1'b1; RD_RDY_I = 1'b0;
        @(negedge CLK_I);
        RD_REQ_I = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == abort_i) return;
            check_eq("rd_issue_state", 32'(STATE_O), 32'd5);
            check_eq("rd_b_strobe", 32'({RAM_B_CS_O, RAM_B_RE_O}), 32'd3);
            check_eq("rd_b_addr", 32'(RAM_B_ADDR_O), 32'((base + i) % N));
            check_eq("rd_a_quiet", 32'(RAM_A_CS_O) | 32'(DONE_O), 32'd0);
            @(negedge CLK_I);
            check_eq("rd_wait_state", 32'(STATE_O), 32'd6);
            check_eq("rd_wait_quiet", 32'({RAM_B_CS_O, RD_VLD_O}), 32'd0);
            @(negedge CLK_I);
            check_eq("rd_vld", 32'(RD_VLD_O), 32'd1);
            check_eq("rd_data", 32'(RD_DATA_O), 32'(samp_q[base + i]));
            check_eq("rd_last", 32'(RD_LAST_O), 32'(i == N - 1));
            n = stall ? ((i == 7) ? 5 : $urandom_range(0, 1)) : 0;
            RD_RDY_I = (n == 0);
            for (int s = 0; s < n; s++) begin
                @(negedge CLK_I);
                check_eq("hold_vld", 32'(RD_VLD_O), 32'd1);
                check_eq("hold_data", 32'(RD_DATA_O), 32'(samp_q[base + i]));
                check_eq("hold_last", 32'(RD_LAST_O), 32'(i == N - 1));
                check_eq("hold_b_cs", 32'(RAM_B_CS_O), 32'd0);
                check_eq("hold_state", 32'(STATE_O), 32'd7);
            end
            RD_RDY_I = 1'b1;
            @(negedge CLK_I);
            RD_RDY_I = 1'b0;
        end
        check_eq("rd_end_state", 32'(STATE_O), 32'd0);
        check_eq("rd_end_vld", 32'({RD_VLD_O, RD_LAST_O}), 32'd0);
    endtask

    initial begin
        int pre, t;
        RSTN_I = 1'b0; ARM_I = 1'b0; PRE_I = '0; SAMPLE_I = '0; SAMPLE_VLD_I = 1'b0;
        TRIG_I = 1'b0; RD_REQ_I = 1'b0; RD_RDY_I = 1'b0;
        repeat (3) @(negedge CLK_I);
        check_reset("reset");
        RSTN_I = 1'b1;

        run_capture(100, 300, 1'b0, 1'b1, 1'b0, -1);
        run_readout(100, 300, 1'b1, -1);

        run_capture(0, 0, 1'b0, 1'b1, 1'b0, -1);
        run_readout(0, 0, 1'b0, -1);

        run_capture(511, 600, 1'b0, 1'b1, 1'b0, -1);
        run_readout(511, 600, 1'b0, -1);

        pre = $urandom_range(1, 510);
        t = pre + $urandom_range(0, 300);
        run_capture(pre, t, 1'b1, 1'b0, 1'b0, -1);
        // Re-arm from DONE with a simultaneous read request: arming must win.
        run_capture(100, 300, 1'b1, 1'b1, 1'b1, -1);
        run_readout(100, 300, 1'b1, -1);

        run_capture(100, 300, 1'b0, 1'b1, 1'b0, 400);
        do_reset("rst_post");
        run_capture(37, 50, 1'b1, 1'b0, 1'b0, -1);
        run_readout(37, 50, 1'b0, 20);
        do_reset("rst_rd");
        run_capture(pre, t, 1'b1, 1'b0, 1'b0, -1);
        run_readout(pre, t, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
